// File: rtl/cube_move_sequencer.sv
// Move sequencer for the cube engine: arbitrates scramble, manual and solver
// move sources and presents one move at a time until the cube register acks it.
module cube_move_sequencer #(
  parameter int SCRAMBLE_LEN = 30,
  parameter int FIFO_DEPTH   = 8,
  parameter int COUNT_MAX    = 999
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scr_start,
  input  logic [2:0] rnd_face,
  input  logic [1:0] rnd_rot,
  input  logic       man_req,
  input  logic [5:0] man_face,
  input  logic [1:0] man_rot,
  input  logic       sol_valid,
  input  logic [2:0] sol_face,
  input  logic [1:0] sol_rot,
  output logic       sol_ready,
  input  logic       sol_flush,
  output logic       mv_valid,
  output logic [2:0] mv_face,
  output logic [2:0] mv_rot,
  output logic [1:0] mv_src,
  input  logic       mv_ack,
  output logic       busy,
  output logic       scr_done,
  output logic [9:0] move_count,
  output logic [1:0] dbg_state
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FIFO_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [9:0]  CMAX      = 10'(COUNT_MAX);
  localparam logic [5:0]  SCR_LAST  = 6'(SCRAMBLE_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_SCRAMBLE = 2'd2
  } state_t;

  state_t     state;
  logic       scr_pend;
  logic       man_pend;
  logic       man_req_q;
  logic [2:0] man_face_q;
  logic [2:0] man_rot_q;
  logic [5:0] scr_cnt;

  logic [4:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fifo_cnt;

  logic       man_edge;
  logic       man_ok;
  logic       fifo_empty;
  logic       push;
  logic       pop;
  logic       in_idle;
  logic       grant_scr;
  logic       grant_man;
  logic [4:0] head;
  logic       head_ok;

  // Random/solver rotation: 0=CW, 1=CCW, 2=double, 3 folds to CW.
  function automatic logic [2:0] map_rot(input logic [1:0] r);
    case (r)
      2'd1:    map_rot = 3'd3;
      2'd2:    map_rot = 3'd2;
      default: map_rot = 3'd1;
    endcase
  endfunction

  function automatic logic [2:0] map_man_rot(input logic [1:0] r);
    case (r)
      2'b10:   map_man_rot = 3'd3;
      2'b11:   map_man_rot = 3'd2;
      default: map_man_rot = 3'd1;
    endcase
  endfunction

  // Generator faces 6 and 7 fold onto 0 and 1.
  function automatic logic [2:0] map_face(input logic [2:0] f);
    map_face = (f > 3'd5) ? {2'b00, f[0]} : f;
  endfunction

  // Solver port: an entry transfers on any edge where sol_valid && sol_ready;
  // sol_ready is low only while the queue holds FIFO_DEPTH entries.
  assign fifo_empty = (fifo_cnt == '0);
  assign sol_ready  = (fifo_cnt != FIFO_FULL);
  assign push       = sol_valid && sol_ready;

  assign man_edge  = man_req && !man_req_q;
  assign man_ok    = man_edge && (man_rot != 2'b00) && (man_face <= 6'd5) &&
                     !man_pend && (state != S_SCRAMBLE);

  assign in_idle   = (state == S_IDLE);
  assign grant_scr = in_idle && scr_pend;
  assign grant_man = in_idle && !scr_pend && man_pend;
  assign pop       = in_idle && !scr_pend && !man_pend && !fifo_empty;
  assign head      = fifo_mem[rd_ptr];
  assign head_ok   = (head[4:2] <= 3'd5);

  assign busy      = (state != S_IDLE) || scr_pend;
  assign dbg_state = state;

  // Queue storage carries no reset; emptiness is tracked by fifo_cnt.
  always_ff @(posedge clk) begin
    if (push && !sol_flush) fifo_mem[wr_ptr] <= {sol_face, sol_rot};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (sol_flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      man_req_q  <= 1'b0;
      man_pend   <= 1'b0;
      man_face_q <= 3'd0;
      man_rot_q  <= 3'd0;
      scr_pend   <= 1'b0;
    end else begin
      man_req_q <= man_req;
      if (man_ok) begin
        man_pend   <= 1'b1;
        man_face_q <= man_face[2:0];
        man_rot_q  <= map_man_rot(man_rot);
      end else if (grant_man) begin
        man_pend <= 1'b0;
      end
      if (scr_start && (state != S_SCRAMBLE)) scr_pend <= 1'b1;
      else if (grant_scr)                     scr_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      mv_valid   <= 1'b0;
      mv_face    <= 3'd0;
      mv_rot     <= 3'd0;
      mv_src     <= 2'd0;
      scr_cnt    <= 6'd0;
      scr_done   <= 1'b0;
      move_count <= 10'd0;
    end else begin
      scr_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_scr) begin
            mv_face  <= map_face(rnd_face);
            mv_rot   <= map_rot(rnd_rot);
            mv_src   <= 2'd0;
            mv_valid <= 1'b1;
            scr_cnt  <= SCR_LAST;
            state    <= S_SCRAMBLE;
          end else if (grant_man) begin
            mv_face  <= man_face_q;
            mv_rot   <= man_rot_q;
            mv_src   <= 2'd1;
            mv_valid <= 1'b1;
            state    <= S_ISSUE;
          end else if (pop && head_ok) begin
            mv_face  <= head[4:2];
            mv_rot   <= map_rot(head[1:0]);
            mv_src   <= 2'd2;
            mv_valid <= 1'b1;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (mv_ack) begin
            if (move_count < CMAX) move_count <= move_count + 10'd1;
            mv_valid <= 1'b0;
            state    <= S_IDLE;
          end
        end
        S_SCRAMBLE: begin
          // Reloading on the ack edge keeps moves back-to-back under a tied-high ack.
          if (mv_ack) begin
            if (scr_cnt != 6'd0) begin
              mv_face <= map_face(rnd_face);
              mv_rot  <= map_rot(rnd_rot);
              scr_cnt <= scr_cnt - 6'd1;
            end else begin
              mv_valid <= 1'b0;
              scr_done <= 1'b1;
              state    <= S_IDLE;
            end
          end
        end
        default: begin
          mv_valid <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cube_move_sequencer.sv
// Directed bench for cube_move_sequencer: scramble, manual, solver queue,
// counter saturation and asynchronous reset scenarios.
module tb_cube_move_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scr_start = 1'b0;
  logic [2:0] rnd_face = 3'd0;
  logic [1:0] rnd_rot = 2'd0;
  logic       man_req = 1'b0;
  logic [5:0] man_face = 6'd0;
  logic [1:0] man_rot = 2'd0;
  logic       sol_valid = 1'b0;
  logic [2:0] sol_face = 3'd0;
  logic [1:0] sol_rot = 2'd0;
  logic       sol_ready;
  logic       sol_flush = 1'b0;
  logic       mv_valid;
  logic [2:0] mv_face;
  logic [2:0] mv_rot;
  logic [1:0] mv_src;
  logic       mv_ack = 1'b0;
  logic       busy;
  logic       scr_done;
  logic [9:0] move_count;
  logic [1:0] dbg_state;

  int n_vec = 0;
  int n_err = 0;

  cube_move_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scr_start  (scr_start),
    .rnd_face   (rnd_face),
    .rnd_rot    (rnd_rot),
    .man_req    (man_req),
    .man_face   (man_face),
    .man_rot    (man_rot),
    .sol_valid  (sol_valid),
    .sol_face   (sol_face),
    .sol_rot    (sol_rot),
    .sol_ready  (sol_ready),
    .sol_flush  (sol_flush),
    .mv_valid   (mv_valid),
    .mv_face    (mv_face),
    .mv_rot     (mv_rot),
    .mv_src     (mv_src),
    .mv_ack     (mv_ack),
    .busy       (busy),
    .scr_done   (scr_done),
    .move_count (move_count),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_scramble(output int nv, output int nd, output int span,
                              output int ff, output int fr);
    int first;
    int last;
    nv = 0; nd = 0; ff = -1; fr = -1;
    first = -1; last = -1;
    scr_start = 1'b1;
    mv_ack = 1'b1;
    step();
    scr_start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (mv_valid && mv_src == 2'd0) begin
        if (first < 0) begin
          first = i;
          ff = int'(mv_face);
          fr = int'(mv_rot);
        end
        last = i;
        nv++;
      end
      if (scr_done) nd++;
    end
    mv_ack = 1'b0;
    span = (first < 0) ? 0 : (last - first + 1);
  endtask

  initial begin
    int nv, nd, span, ff, fr;
    int acc, seen, got, guard, first_rot;
    int exp_count;

    // Reset state
    repeat (2) step();
    check("rst_mv_valid", mv_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_count", move_count, 0);
    check("rst_sol_ready", sol_ready, 1);
    check("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    step();

    // Full scramble with ack tied high; face 6 folds to 0, CCW maps to 3
    rnd_face = 3'd6; rnd_rot = 2'd1;
    run_scramble(nv, nd, span, ff, fr);
    check("scr_valid_cycles", nv, 30);
    check("scr_consecutive", span, 30);
    check("scr_done_pulses", nd, 1);
    check("scr_first_face", ff, 0);
    check("scr_first_rot", fr, 3);
    check("scr_count_unchanged", move_count, 0);
    check("scr_idle_after", busy, 0);

    // Invalid manual requests are dropped
    man_face = 6'd6; man_rot = 2'b01; man_req = 1'b1; step();
    man_req = 1'b0; step();
    man_face = 6'd2; man_rot = 2'b00; man_req = 1'b1; step();
    man_req = 1'b0;
    repeat (3) step();
    check("man_invalid_valid", mv_valid, 0);
    check("man_invalid_busy", busy, 0);

    // Manual face 4 CCW, ack after three presented cycles
    man_face = 6'd4; man_rot = 2'b10; man_req = 1'b1;
    step();
    step();
    check("man_valid_c1", mv_valid, 1);
    check("man_face", mv_face, 4);
    check("man_rot", mv_rot, 3);
    check("man_src", mv_src, 1);
    step();
    step();
    check("man_hold_valid", mv_valid, 1);
    check("man_hold_face", mv_face, 4);
    check("man_hold_rot", mv_rot, 3);
    mv_ack = 1'b1; step(); mv_ack = 1'b0;
    check("man_done_valid", mv_valid, 0);
    check("man_count", move_count, 1);
    man_req = 1'b0; step();

    // Manual and solver pending in the same idle cycle: manual first
    sol_valid = 1'b1; sol_face = 3'd2; sol_rot = 2'd2;
    man_face = 6'd1; man_rot = 2'b01; man_req = 1'b1;
    step();
    sol_valid = 1'b0;
    step();
    check("prio_src_manual", mv_src, 1);
    check("prio_man_face", mv_face, 1);
    check("prio_man_rot", mv_rot, 1);
    mv_ack = 1'b1; step(); mv_ack = 1'b0;
    step();
    check("prio_sol_valid", mv_valid, 1);
    check("prio_src_solver", mv_src, 2);
    check("prio_sol_face", mv_face, 2);
    check("prio_sol_rot", mv_rot, 2);
    mv_ack = 1'b1; step(); mv_ack = 1'b0;
    check("prio_count", move_count, 3);
    man_req = 1'b0; step();

    // Manual edge and scr_start during a scramble are both dropped
    rnd_face = 3'd2; rnd_rot = 2'd0;
    scr_start = 1'b1; step(); scr_start = 1'b0;
    step();
    check("scr2_busy", busy, 1);
    check("scr2_src", mv_src, 0);
    man_face = 6'd3; man_rot = 2'b01; man_req = 1'b1; step();
    scr_start = 1'b1; step(); scr_start = 1'b0;
    mv_ack = 1'b1;
    got = 0;
    for (int i = 0; i < 40 && got == 0; i++) begin
      step();
      if (scr_done) got = 1;
    end
    mv_ack = 1'b0;
    check("scr2_done_seen", got, 1);
    repeat (4) step();
    check("scr2_no_manual", mv_valid, 0);
    check("scr2_no_restart", busy, 0);
    check("scr2_count", move_count, 3);
    man_req = 1'b0; step();

    // Solver entry with face 7 is discarded without issue
    sol_valid = 1'b1; sol_face = 3'd7; sol_rot = 2'd0; step();
    sol_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (mv_valid) seen++;
      step();
    end
    check("sol_bad_face_seen", seen, 0);
    check("sol_bad_face_ready", sol_ready, 1);

    // Queue fills behind an outstanding manual move, then flush
    man_face = 6'd5; man_rot = 2'b11; man_req = 1'b1;
    step(); step();
    check("q_man_face", mv_face, 5);
    check("q_man_rot", mv_rot, 2);
    man_req = 1'b0;
    acc = 0;
    for (int k = 0; k < 9; k++) begin
      sol_valid = 1'b1; sol_face = 3'(k % 6); sol_rot = 2'(k % 4);
      if (sol_ready) acc++;
      step();
    end
    sol_valid = 1'b0;
    check("q_accepted", acc, 8);
    check("q_full_ready", sol_ready, 0);
    check("q_move_held", mv_src, 1);
    sol_flush = 1'b1; step(); sol_flush = 1'b0;
    check("q_flush_ready", sol_ready, 1);
    check("q_flush_keeps_move", mv_valid, 1);
    mv_ack = 1'b1; step(); mv_ack = 1'b0;
    check("q_ack_valid", mv_valid, 0);
    check("q_count", move_count, 4);
    repeat (4) step();
    check("q_empty_no_issue", mv_valid, 0);

    // Saturation: stream solver moves until the count reaches 999
    exp_count = 4;
    first_rot = -1;
    sol_face = 3'd1; sol_rot = 2'd3; sol_valid = 1'b1; mv_ack = 1'b1;
    guard = 0;
    while (exp_count < 999 && guard < 5000) begin
      if (mv_valid && mv_src == 2'd2) begin
        if (first_rot < 0) first_rot = int'(mv_rot);
        exp_count++;
      end
      step();
      guard++;
    end
    sol_valid = 1'b0;
    check("sat_budget", (guard < 5000) ? 1 : 0, 1);
    check("sat_rot3_to_cw", first_rot, 1);
    check("sat_reach", move_count, 999);
    repeat (40) step();
    check("sat_drain", move_count, 999);
    sol_valid = 1'b1; step(); sol_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (mv_valid && mv_src == 2'd2) seen++;
      step();
    end
    mv_ack = 1'b0;
    check("sat_extra_issued", seen, 1);
    check("sat_hold", move_count, 999);

    // Asynchronous reset in the middle of a scramble
    rnd_face = 3'd3; rnd_rot = 2'd2;
    scr_start = 1'b1; step(); scr_start = 1'b0;
    step();
    mv_ack = 1'b1;
    repeat (10) step();
    mv_ack = 1'b0;
    check("pre_rst_valid", mv_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", mv_valid, 0);
    check("arst_face", mv_face, 0);
    check("arst_rot", mv_rot, 0);
    check("arst_src", mv_src, 0);
    check("arst_busy", busy, 0);
    check("arst_done", scr_done, 0);
    check("arst_count", move_count, 0);
    check("arst_ready", sol_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    run_scramble(nv, nd, span, ff, fr);
    check("post_rst_valid_cycles", nv, 30);
    check("post_rst_consecutive", span, 30);
    check("post_rst_done", nd, 1);
    check("post_rst_face", ff, 3);
    check("post_rst_rot", fr, 2);
    check("post_rst_count", move_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cube_move_sequencer.md
Name: cube_move_sequencer

Overview:
- Sole controller of the combinational cube move engine and the cube-state register that commits its result.
- Arbitrates three move sources: the random scramble generator, the manual key/switch input and a solver move stream.
- Issues one move at a time to the engine's face and quarter-turn-count inputs, and keeps the scramble and user-move counters used by the HEX display.

Parameters:
SCRAMBLE_LEN, 30, number of random moves applied per scramble (1..63)
FIFO_DEPTH, 8, solver move FIFO entries (power of two, 2..32)
COUNT_MAX, 999, saturation value of move_count (fits 3 decimal digits)

Ports:
clk  in  1  system clock (CLOCK_50)
rst_n  in  1  asynchronous active-low reset (one clock; reset is asynchronous and active-low)
scr_start  in  1  request a scramble, single-cycle pulse
rnd_face  in  3  random face from move generator
rnd_rot  in  2  random rotation: 0=CW, 1=CCW, 2=double, 3=treated as CW
man_req  in  1  manual move strobe, level; rising edge is the request
man_face  in  6  manual face select; only 0..5 are valid
man_rot  in  2  00=none, 01=CW, 10=CCW, 11=double
sol_valid  in  1  solver move valid
sol_face  in  3  solver face 0..5
sol_rot  in  2  same encoding as rnd_rot
sol_ready  out  1  solver FIFO not full
sol_flush  in  1  discard all queued solver moves
mv_valid  out  1  move presented to the engine
mv_face  out  3  face to the engine (datapath zero-extends)
mv_rot  out  3  quarter-turn count: 1=CW, 2=double, 3=CCW
mv_src  out  2  0=scramble, 1=manual, 2=solver
mv_ack  in  1  cube register committed the move this cycle
busy  out  1  scramble active or move outstanding
scr_done  out  1  one-cycle pulse after the last scramble ack
move_count  out  10  committed manual and solver moves, saturating

Behaviour:
- Reset (async, rst_n=0) clears everything immediately: state=IDLE, mv_valid=0, mv_face=0, mv_rot=0, mv_src=0, busy=0, scr_done=0, move_count=0, FIFO empty, so sol_ready=1 the first cycle after release. All pending flags and the scramble counter clear.
- A reset mid-move or mid-scramble abandons the operation. No ack is expected afterwards.
- FSM states:
  - IDLE: mv_valid=0. Arbitrates each cycle in fixed priority: pending scramble > pending manual > FIFO head.
    - Scramble winner: load rnd_face/rnd_rot, set scr_cnt=SCRAMBLE_LEN-1, go to SCRAMBLE.
    - Manual or solver winner: load payload, go to ISSUE.
    - Grant to move presented: 1 cycle.
  - ISSUE: mv_valid=1; payload is stable until mv_ack. On mv_ack: increment move_count if below COUNT_MAX, then go to IDLE.
  - SCRAMBLE: mv_valid=1, mv_src=0. On mv_ack:
    - scr_cnt>0: reload from rnd_face/rnd_rot in the same cycle, decrement scr_cnt, stay. This gives back-to-back moves when ack is tied high.
    - scr_cnt==0: go to IDLE and pulse scr_done next cycle.
    - Scramble moves never change move_count.
- Rotation mapping: CW→1, CCW→3, double→2. rnd_rot/sol_rot 3→1. rnd_face 6→0, 7→1.
- Pending scramble:
  - scr_start sets the flag whenever state≠SCRAMBLE. It is consumed at grant.
  - scr_start during SCRAMBLE is ignored.
  - If a single move is outstanding in ISSUE, that move finishes first.
- Manual input:
  - Rising edge of man_req, sampled registered, sets the manual pending flag and captures man_face/man_rot, only if man_rot≠00, man_face≤5, no manual move is pending and state≠SCRAMBLE. Otherwise the edge is dropped.
  - The first capture wins; later edges do not overwrite it.
- Solver FIFO:
  - Push on sol_valid&&sol_ready, accepted in every state including SCRAMBLE.
  - Pop at grant.
  - sol_face>5 entries are popped and discarded without issue.
  - sol_flush empties the FIFO next cycle and takes priority over a simultaneous push. It does not cancel a move already in ISSUE.
  - Full: sol_ready=0, input held off.
  - Push and pop in the same cycle when full is legal (ready reflects the pre-pop count).
- busy = (state≠IDLE) || scramble pending.
- mv_ack while mv_valid=0 is ignored.

Test Plan:
- Reset, scr_start pulse, mv_ack tied 1 → exactly 30 consecutive mv_valid cycles with mv_src=0, scr_done once, move_count stays 0.
- man_req edge with man_face=4, man_rot=10, ack after 3 cycles → mv_face=4, mv_rot=3 held 3 cycles; move_count=1.
- Manual edge and FIFO non-empty in the same IDLE cycle → manual issued first, then solver; man_req edge during scramble → dropped, move_count unchanged.
- Push 9 solver moves with no ack → sol_ready drops after 8 accepted; ninth held; sol_flush → FIFO empty and the outstanding move still completes on ack.
- Reach 999 via 999 acked solver moves, push one more → move_count stays 999.
- rst_n low mid-scramble (after 10 acks) → all outputs 0 asynchronously; scr_start after release → full 30-move scramble.
